// File: rtl/vote_pkg.sv
// Shared types and constants for the three-voter ballot sequencer.
package vote_pkg;
  localparam int NUM_VOTERS = 3;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    HOLD    = 2'd3
  } vote_state_t;
endpackage

// File: rtl/vote_sequencer_if.sv
// Ballot bus: control/vote inputs from the master, status and result back from the sequencer.
interface vote_sequencer_if;
  import vote_pkg::*;

  logic                  start;
  logic [NUM_VOTERS-1:0] vote_valid;
  logic [NUM_VOTERS-1:0] vote_val;
  logic                  busy;
  logic [NUM_VOTERS-1:0] voted;
  logic                  result;
  logic                  result_valid;
  logic                  result_ready;
  logic                  timed_out;

  modport master (
    output start, vote_valid, vote_val, result_ready,
    input  busy, voted, result, result_valid, timed_out
  );

  modport slave (
    input  start, vote_valid, vote_val, result_ready,
    output busy, voted, result, result_valid, timed_out
  );
endinterface

// File: rtl/maj3_voter.sv
// Combinational 2-of-3 majority.
module maj3_voter (
  input  logic [2:0] votes,
  output logic       maj
);
  assign maj = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
endmodule

// File: rtl/vote_sequencer.sv
// Ballot sequencer: collects one vote per voter, decides by majority, holds the result
// until accepted. Define VOTE_SEQUENCER_TIMEOUT_EN to force a ballot closed after TIMEOUT_CYCLES.
module vote_sequencer
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             rst_n,
  vote_sequencer_if.slave bus
);
  localparam logic [NUM_VOTERS-1:0] ALL_VOTED = '1;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..255");
  end

  vote_state_t           state;
  logic [NUM_VOTERS-1:0] voted, votes;
  logic [NUM_VOTERS-1:0] acc, mask_nxt, votes_nxt;
  logic                  result_q, result_valid_q, maj;

  // First strobe per voter wins; later strobes from the same voter are dropped.
  assign acc       = bus.vote_valid & ~voted;
  assign mask_nxt  = voted | acc;
  assign votes_nxt = votes | (bus.vote_val & acc);

  maj3_voter u_maj (
    .votes (votes & voted),
    .maj   (maj)
  );

`ifdef VOTE_SEQUENCER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             timed_out_q;
  logic             expire;

  assign expire = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      timed_out_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      cnt         <= '0;
      timed_out_q <= 1'b0;
    end else if (state == COLLECT) begin
      cnt <= cnt + 1'b1;
      if (mask_nxt != ALL_VOTED && expire) timed_out_q <= 1'b1;
    end
  end

  assign bus.timed_out = timed_out_q;
`else
  logic expire;
  assign expire        = 1'b0;
  assign bus.timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      voted          <= '0;
      votes          <= '0;
      result_q       <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= COLLECT;
          voted <= '0;
          votes <= '0;
        end
        COLLECT: begin
          voted <= mask_nxt;
          votes <= votes_nxt;
          if (mask_nxt == ALL_VOTED || expire) state <= DECIDE;
        end
        DECIDE: begin
          result_q <= maj;
          state    <= HOLD;
        end
        HOLD: begin
          // Valid rises the cycle after the result register loads, then waits for ready.
          if (!result_valid_q) begin
            result_valid_q <= 1'b1;
          end else if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.voted        = voted;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_vote_sequencer.sv
// Directed bench for vote_sequencer; timeout scenario runs when VOTE_SEQUENCER_TIMEOUT_EN is defined.
module tb_vote_sequencer;
`ifdef VOTE_SEQUENCER_TIMEOUT_EN
  localparam int TC = 4;
`else
  localparam int TC = 16;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vote_sequencer_if bus ();

  vote_sequencer #(.TIMEOUT_CYCLES(TC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start        = 1'b0;
    bus.vote_valid   = 3'b000;
    bus.vote_val     = 3'b000;
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.start = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.busy, bus.voted, bus.result, bus.result_valid, bus.timed_out} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {bus.busy, bus.voted, bus.result, bus.result_valid, bus.timed_out});
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  // Votes 1,1,0 on separate cycles; exact latency from last vote.
  task automatic test_sequential_votes();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL seq_busy: got %b expected 1", bus.busy);
    end
    bus.vote_valid = 3'b001; bus.vote_val = 3'b001; tick();
    checks++;
    if (bus.voted !== 3'b001) begin
      errors++; $display("FAIL seq_voted0: got %b expected 001", bus.voted);
    end
    bus.vote_valid = 3'b010; bus.vote_val = 3'b010; tick();
    bus.vote_valid = 3'b100; bus.vote_val = 3'b000; tick();  // edge N
    bus.vote_valid = 3'b000; bus.vote_val = 3'b000;
    tick();                                                   // edge N+1
    checks++;
    if (bus.result_valid !== 1'b0) begin
      errors++; $display("FAIL seq_early_valid: got %b expected 0 after N+1", bus.result_valid);
    end
    tick();                                                   // edge N+2
    checks++;
    if ({bus.result_valid, bus.result, bus.timed_out, bus.voted} !== 6'b110_111) begin
      errors++;
      $display("FAIL seq_result: got valid/result/to/voted %b expected 110111",
               {bus.result_valid, bus.result, bus.timed_out, bus.voted});
    end
    bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
    checks++;
    if ({bus.result_valid, bus.busy, bus.voted} !== 5'b00_111) begin
      errors++;
      $display("FAIL seq_release: got valid/busy/voted %b expected 00111",
               {bus.result_valid, bus.busy, bus.voted});
    end
    // Votes in IDLE must not disturb the retained mask.
    bus.vote_valid = 3'b111; bus.vote_val = 3'b000; tick();
    bus.vote_valid = 3'b000;
    checks++;
    if ({bus.busy, bus.voted, bus.result} !== 5'b0_111_1) begin
      errors++;
      $display("FAIL idle_votes_ignored: got busy/voted/result %b expected 01111",
               {bus.busy, bus.voted, bus.result});
    end
  endtask

  task automatic test_single_cycle();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    checks++;
    if (bus.voted !== 3'b000) begin
      errors++; $display("FAIL single_cleared: got %b expected 000", bus.voted);
    end
    bus.vote_valid = 3'b111; bus.vote_val = 3'b010; tick();
    bus.vote_valid = 3'b000; bus.vote_val = 3'b000;
    for (int i = 0; i < 10 && !bus.result_valid; i++) tick();
    checks++;
    if ({bus.result_valid, bus.result, bus.voted} !== 5'b10_111) begin
      errors++;
      $display("FAIL single_result: got valid/result/voted %b expected 10111",
               {bus.result_valid, bus.result, bus.voted});
    end
    bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
  endtask

  task automatic test_repeat_strobe();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.vote_valid = 3'b001; bus.vote_val = 3'b001; tick();
    bus.vote_valid = 3'b001; bus.vote_val = 3'b000; tick();
    checks++;
    if ({bus.busy, bus.voted} !== 4'b1_001) begin
      errors++;
      $display("FAIL repeat_mask: got busy/voted %b expected 1001", {bus.busy, bus.voted});
    end
    bus.vote_valid = 3'b110; bus.vote_val = 3'b100; tick();
    bus.vote_valid = 3'b000; bus.vote_val = 3'b000;
    for (int i = 0; i < 10 && !bus.result_valid; i++) tick();
    checks++;
    if ({bus.result_valid, bus.result} !== 2'b11) begin
      errors++;
      $display("FAIL repeat_result: got valid/result %b expected 11",
               {bus.result_valid, bus.result});
    end
    bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
  endtask

`ifdef VOTE_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.vote_valid = 3'b100; bus.vote_val = 3'b100; tick();   // COLLECT cycle 1
    bus.vote_valid = 3'b000; bus.vote_val = 3'b000;
    tick(); tick();                                           // cycles 2,3
    checks++;
    if (bus.timed_out !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got %b expected 0", bus.timed_out);
    end
    tick();                                                   // cycle 4 closes ballot
    checks++;
    if ({bus.timed_out, bus.result_valid} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_fire: got to/valid %b expected 10", {bus.timed_out, bus.result_valid});
    end
    tick(); tick();
    checks++;
    if ({bus.result_valid, bus.result, bus.timed_out, bus.voted} !== 6'b101_100) begin
      errors++;
      $display("FAIL timeout_result: got valid/result/to/voted %b expected 101100",
               {bus.result_valid, bus.result, bus.timed_out, bus.voted});
    end
    bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
    checks++;
    if ({bus.result_valid, bus.busy, bus.timed_out} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_release: got valid/busy/to %b expected 001",
               {bus.result_valid, bus.busy, bus.timed_out});
    end
  endtask
`endif

  task automatic test_hold_stall();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.vote_valid = 3'b111; bus.vote_val = 3'b111; tick();
    bus.vote_valid = 3'b000; bus.vote_val = 3'b000;
    for (int i = 0; i < 10 && !bus.result_valid; i++) tick();
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL hold_wait: got valid %b expected 1 within budget", bus.result_valid);
    end
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1; tick();
      checks++;
      if ({bus.result_valid, bus.result, bus.busy} !== 3'b111) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got valid/result/busy %b expected 111", i,
                 {bus.result_valid, bus.result, bus.busy});
      end
    end
    bus.result_ready = 1'b1; bus.start = 1'b1; tick();
    bus.result_ready = 1'b0; bus.start = 1'b0;
    checks++;
    if ({bus.result_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL hold_release: got valid/busy %b expected 00", {bus.result_valid, bus.busy});
    end
    tick(); tick();
    checks++;
    if ({bus.busy, bus.voted} !== 4'b0_111) begin
      errors++;
      $display("FAIL hold_no_restart: got busy/voted %b expected 0111", {bus.busy, bus.voted});
    end
  endtask

  task automatic test_reset_mid_collect();
    int pulses;
    pulses = 0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.vote_valid = 3'b011; bus.vote_val = 3'b011; tick();
    checks++;
    if (bus.voted !== 3'b011) begin
      errors++; $display("FAIL midrst_voted: got %b expected 011", bus.voted);
    end
    rst_n = 1'b0; bus.start = 1'b1; bus.vote_valid = 3'b111; bus.vote_val = 3'b111;
    tick();
    checks++;
    if ({bus.busy, bus.voted, bus.result, bus.result_valid, bus.timed_out} !== 7'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got %b expected 0000000",
               {bus.busy, bus.voted, bus.result, bus.result_valid, bus.timed_out});
    end
    rst_n = 1'b1; idle_inputs();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.result_valid || bus.busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL midrst_no_result: got %0d active cycles expected 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_sequential_votes();
    test_single_cycle();
    test_repeat_strobe();
`ifdef VOTE_SEQUENCER_TIMEOUT_EN
    test_timeout();
`endif
    test_hold_stall();
    test_reset_mid_collect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
